// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures period and high time of an incoming PWM waveform in clk cycles.
//   Both values are reported once per PWM period with a one-cycle valid strobe.
//   A line that stops toggling is flagged as stuck after TIMEOUT_CYCLES cycles
//   without a rising edge.
//
// Ports
//   clk          system clock, posedge
//   rst          asynchronous active-low reset
//   pwm_in       asynchronous PWM input
//   period       cycles between the last two rising edges
//   high_time    cycles the input was high within that period
//   valid        one-cycle strobe, period/high_time updated in the same cycle
//   stuck        set on timeout, cleared on the next valid
//   stuck_level  input level seen at timeout (0 = stuck low, 1 = stuck high)
//
// Build option
//   PWM_CAPTURE_FILTER_EN  inserts a glitch filter of FILTER_LEN cycles
//                          between the synchronizer and the edge detector.
//
// state | meaning
// IDLE  | waiting for the first rising edge
// ARMED | first edge seen, no complete period measured yet
// RUN   | every rising edge reports a full period

`timescale 1ns/1ps

module pwm_capture #(
    parameter int CNT_WIDTH      = 20,
    parameter int TIMEOUT_CYCLES = 2**CNT_WIDTH - 1,
    parameter int FILTER_LEN     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 stuck,
    output logic                 stuck_level
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("pwm_capture: TIMEOUT_CYCLES must be >= 2");
    end
    if (FILTER_LEN < 2) begin : g_bad_filter
        $error("pwm_capture: FILTER_LEN must be >= 2");
    end

    logic                 meta;
    logic                 s1;
    logic                 s2;
    logic                 lvl;
    logic                 rise;
    logic                 fall;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] hi_latch;
    state_t               state_q;
    state_t               state_d;
    logic                 meas;
    logic                 tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            s1   <= 1'b0;
        end else begin
            meta <= pwm_in;
            s1   <= meta;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] F_ONE  = FW'(1);

    logic [FW-1:0] fcnt;
    logic          filt;

    // The filtered level follows s1 only after s1 has differed from it for
    // FILTER_LEN consecutive cycles, so both edges get the same delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt <= '0;
            filt <= 1'b0;
        end else if (s1 == filt) begin
            fcnt <= '0;
        end else if (fcnt == F_LAST) begin
            fcnt <= '0;
            filt <= s1;
        end else begin
            fcnt <= fcnt + F_ONE;
        end
    end

    assign lvl = filt;
`else
    assign lvl = s1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2 <= 1'b0;
        end else begin
            s2 <= lvl;
        end
    end

    assign rise = lvl & ~s2;
    assign fall = ~lvl & s2;

    // cnt holds the number of cycles since the last rise, inclusive of the
    // current one, so on the next rise it equals the period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            hi_latch <= '0;
        end else begin
            if (rise) begin
                cnt <= CNT_ONE;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end
            if (fall) begin
                hi_latch <= cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        meas    = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // This rise closes a full period, but hi_latch may predate
                // the first rise, so it is dropped.
                if (rise) begin
                    state_d = RUN;
                end else if (cnt == TIMEOUT_VAL) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (rise) begin
                    meas = 1'b1;
                end else if (cnt == TIMEOUT_VAL) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid <= meas;
            if (meas) begin
                period    <= cnt;
                high_time <= hi_latch;
                stuck     <= 1'b0;
            end else if (tmo) begin
                period      <= '0;
                high_time   <= '0;
                stuck       <= 1'b1;
                stuck_level <= lvl;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps

module tb_pwm_capture;

    localparam int CW = 20;

    logic          clk;
    logic          rst;
    logic          pwm_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          stuck;
    logic          stuck_level;

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    logic [CW-1:0] cap_period = '0;
    logic [CW-1:0] cap_high   = '0;

    pwm_capture #(
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (1000),
        .FILTER_LEN     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .period      (period),
        .high_time   (high_time),
        .valid       (valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every valid strobe on the falling edge, away from the update.
    always @(negedge clk) begin
        if (valid) begin
            vcnt       <= vcnt + 1;
            cap_period <= period;
            cap_high   <= high_time;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    task automatic drive_period(input int p, input int h);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    task automatic glitch_period();
        hold(1'b1, 25);
        hold(1'b0, 35);
        hold(1'b1, 2);
        hold(1'b0, 38);
    endtask

    int base;

    initial begin
        rst    = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_level", stuck_level, 0);
        rst = 1'b1;

        // Steady 100/25: first two rises stay silent, third reports.
        base = vcnt;
        drive_period(100, 25); #1;
        check("t1_rise1_novalid", vcnt - base, 0);
        drive_period(100, 25); #1;
        check("t1_rise2_novalid", vcnt - base, 0);
        drive_period(100, 25); #1;
        check("t1_rise3_valid", vcnt - base, 1);
        check("t1_period", cap_period, 100);
        check("t1_high", cap_high, 25);
        check("t1_stuck", stuck, 0);
        repeat (3) drive_period(100, 25);
        #1;
        check("t1_valid_count", vcnt - base, 4);
        check("t1_period_steady", cap_period, 100);

        // Switch to 200/150; the second new rise reports a full new period.
        base = vcnt;
        drive_period(200, 150); #1;
        check("t2_first_valid", vcnt - base, 1);
        drive_period(200, 150); #1;
        check("t2_period", cap_period, 200);
        check("t2_high", cap_high, 150);
        drive_period(200, 150); #1;
        check("t2_valid_count", vcnt - base, 3);
        check("t2_period_steady", cap_period, 200);

        // Back to 100/25, then hold low until timeout.
        repeat (3) drive_period(100, 25);
        hold(1'b0, 895); #1;
        check("t3_low_not_yet", stuck, 0);
        hold(1'b0, 20); #1;
        check("t3_low_stuck", stuck, 1);
        check("t3_low_level", stuck_level, 0);
        check("t3_low_period", period, 0);
        check("t3_low_high", high_time, 0);

        base = vcnt;
        drive_period(100, 25);
        drive_period(100, 25); #1;
        check("t3_recover_rise2_stuck", stuck, 1);
        check("t3_recover_rise2_novalid", vcnt - base, 0);
        drive_period(100, 25); #1;
        check("t3_recover_valid", vcnt - base, 1);
        check("t3_recover_stuck", stuck, 0);
        check("t3_recover_period", cap_period, 100);
        check("t3_recover_high", cap_high, 25);

        // Hold high until timeout.
        drive_period(100, 25);
        hold(1'b1, 995); #1;
        check("t4_high_not_yet", stuck, 0);
        hold(1'b1, 20); #1;
        check("t4_high_stuck", stuck, 1);
        check("t4_high_level", stuck_level, 1);
        check("t4_high_period", period, 0);
        hold(1'b0, 50);
        base = vcnt;
        drive_period(100, 25);
        drive_period(100, 25); #1;
        check("t4_recover_rise2_stuck", stuck, 1);
        drive_period(100, 25); #1;
        check("t4_recover_valid", vcnt - base, 1);
        check("t4_recover_stuck", stuck, 0);
        check("t4_recover_period", cap_period, 100);

        // One-cycle reset in the middle of a high phase.
        drive_period(100, 25);
        hold(1'b1, 10);
        rst = 1'b0;
        #1;
        check("t5_rst_period", period, 0);
        check("t5_rst_high", high_time, 0);
        check("t5_rst_valid", valid, 0);
        check("t5_rst_stuck", stuck, 0);
        @(negedge clk);
        rst = 1'b1;
        base = vcnt;
        // The synchronizer restarts from 0 while the pin is still high, so
        // the rest of this high phase registers as the first rise.
        hold(1'b1, 14);
        hold(1'b0, 75); #1;
        check("t5_rise1_novalid", vcnt - base, 0);
        drive_period(100, 25); #1;
        check("t5_rise2_novalid", vcnt - base, 0);
        drive_period(100, 25); #1;
        check("t5_rise3_valid", vcnt - base, 1);
        check("t5_period", cap_period, 100);
        check("t5_high", cap_high, 25);

        // Two-cycle glitches inside the low phase of a 100/25 waveform.
        drive_period(100, 25);
        #1;
        base = vcnt;
        repeat (3) glitch_period();
        #1;
`ifdef PWM_CAPTURE_FILTER_EN
        check("t6_glitch_valids", vcnt - base, 3);
`else
        check("t6_glitch_valids", vcnt - base, 6);
`endif
        drive_period(100, 25); #1;
`ifdef PWM_CAPTURE_FILTER_EN
        check("t6_glitch_period", cap_period, 100);
        check("t6_glitch_high", cap_high, 25);
`else
        check("t6_glitch_period", cap_period, 40);
        check("t6_glitch_high", cap_high, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
